alu_issue_ctrl: RTL and testbench

//  Producer side of the ALU Operation interface: decodes one RV32I instruction per

---
 rtl/alu_issue_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// RV32I issue stage: decodes one instruction per transfer into ALU op code and operands,
// with a main/skid register pair so in_ready comes straight from a flop.
module alu_issue_ctrl #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    instr,
  input  logic [DATA_WIDTH-1:0]    pc,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     is_branch,
  output logic                     illegal
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND  = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR   = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT  = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL  = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL  = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_BEQ  = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] OP_BNE  = OPCODE_LENGTH'(4'b1010);
  localparam logic [OPCODE_LENGTH-1:0] OP_BLT  = OPCODE_LENGTH'(4'b1011);
  localparam logic [OPCODE_LENGTH-1:0] OP_BGE  = OPCODE_LENGTH'(4'b1100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLTU = OPCODE_LENGTH'(4'b1101);
  localparam logic [OPCODE_LENGTH-1:0] OP_BLTU = OPCODE_LENGTH'(4'b1110);
  localparam logic [OPCODE_LENGTH-1:0] OP_BGEU = OPCODE_LENGTH'(4'b1111);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    a;
    logic [DATA_WIDTH-1:0]    b;
    logic [OPCODE_LENGTH-1:0] op;
    logic                     br;
    logic                     ill;
  } entry_t;

  // Shared funct3 map of the R and I ALU groups (SUB/SRA resolved by the caller)
  function automatic logic [OPCODE_LENGTH-1:0] alu_f3(input logic [2:0] f);
    logic [OPCODE_LENGTH-1:0] r;
    r = OP_ADD;
    case (f)
      3'b000:  r = OP_ADD;
      3'b001:  r = OP_SLL;
      3'b010:  r = OP_SLT;
      3'b011:  r = OP_SLTU;
      3'b100:  r = OP_XOR;
      3'b101:  r = OP_SRL;
      3'b110:  r = OP_OR;
      default: r = OP_AND;
    endcase
    return r;
  endfunction

  logic [2:0]            f3;
  logic                  f7_zero;
  logic                  f7_alt;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_u;
  logic                  legal;
  entry_t                dec;

  assign f3      = instr[14:12];
  assign f7_zero = (instr[31:25] == 7'b0000000);
  assign f7_alt  = (instr[31:25] == 7'b0100000);
  assign imm_i   = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
  assign imm_s   = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u   = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'b0};

  always_comb begin
    dec    = '0;
    dec.op = OP_ADD;
    legal  = 1'b1;
    case (instr[6:0])
      7'b0110011: begin
        dec.a  = rs1_data;
        dec.b  = rs2_data;
        dec.op = alu_f3(f3);
        if (f3 == 3'b000 || f3 == 3'b101) begin
          legal = f7_zero | f7_alt;
          if (f7_alt) dec.op = (f3 == 3'b000) ? OP_SUB : OP_SRA;
        end else begin
          legal = f7_zero;
        end
      end
      7'b0010011: begin
        dec.a  = rs1_data;
        dec.b  = imm_i;
        dec.op = alu_f3(f3);
        if (f3 == 3'b001) legal = f7_zero;
        if (f3 == 3'b101) begin
          legal = f7_zero | f7_alt;
          if (f7_alt) dec.op = OP_SRA;
        end
      end
      7'b0000011: begin
        dec.a = rs1_data;
        dec.b = imm_i;
      end
      7'b0100011: begin
        dec.a = rs1_data;
        dec.b = imm_s;
      end
      7'b1100011: begin
        dec.a  = rs1_data;
        dec.b  = rs2_data;
        dec.br = 1'b1;
        case (f3)
          3'b000:  dec.op = OP_BEQ;
          3'b001:  dec.op = OP_BNE;
          3'b100:  dec.op = OP_BLT;
          3'b101:  dec.op = OP_BGE;
          3'b110:  dec.op = OP_BLTU;
          3'b111:  dec.op = OP_BGEU;
          default: legal  = 1'b0;
        endcase
      end
      7'b0110111: dec.b = imm_u;
      7'b0010111: begin
        dec.a = pc;
        dec.b = imm_u;
      end
      7'b1101111: begin
        dec.a = pc;
        dec.b = DATA_WIDTH'(4);
      end
      7'b1100111: begin
        dec.a = pc;
        dec.b = DATA_WIDTH'(4);
        legal = (f3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase
    // Undecodable words still transfer, with a neutral ADD of zeros
    if (!legal) begin
      dec     = '0;
      dec.op  = OP_ADD;
      dec.ill = 1'b1;
    end
  end

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept;
  logic   out_fire;

  assign accept   = in_valid & ~skid_valid_q;
  assign out_fire = main_valid_q & out_ready;

  // Main register feeds the outputs; skid only fills while main is stalled
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end
    end else if (out_fire) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = dec;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign SrcA      = main_q.a;
  assign SrcB      = main_q.b;
  assign Operation = main_q.op;
  assign is_branch = main_q.br;
  assign illegal   = main_q.ill;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed instructions with hand-computed results,
// back-pressure, flush and asynchronous reset scenarios.
module tb_alu_issue_ctrl;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        br;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  Operation;
  logic        is_branch;
  logic        illegal;

  int n_checks = 0;
  int n_pass = 0;
  exp_t sb[$];

  alu_issue_ctrl #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .is_branch(is_branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic br, input logic ill);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.br = br; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_output: got A=%h B=%h op=%h br=%b ill=%b, expected none",
                 SrcA, SrcB, Operation, is_branch, illegal);
      end else begin
        exp_t e;
        exp_t act;
        e = sb.pop_front();
        act = mk(SrcA, SrcB, Operation, is_branch, illegal);
        if (act === e) n_pass++;
        else $display("FAIL output: got A=%h B=%h op=%h br=%b ill=%b, expected A=%h B=%h op=%h br=%b ill=%b",
                      SrcA, SrcB, Operation, is_branch, illegal, e.a, e.b, e.op, e.br, e.ill);
      end
    end
  end

  // Called at posedge+1; holds inputs for one cycle and records the expectation if accepted
  task automatic issue(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                       input logic [31:0] r2, input exp_t e);
    logic acc;
    in_valid = 1'b1; instr = i; pc = p; rs1_data = r1; rs2_data = r2;
    @(negedge clk);
    acc = in_ready && !flush;
    @(posedge clk);
    if (acc) sb.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int budget;
    out_ready = 1'b1;
    in_valid = 1'b0;
    budget = 50;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain_timeout: got %0d entries outstanding, expected 0", sb.size());
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_srca", SrcA, 32'd0);
    chk("reset_op", 32'(Operation), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Single-cycle latency with the sink ready
    out_ready = 1'b1;
    issue(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'b0010, 1'b0, 1'b0));
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Decode vectors, streamed back to back
    issue(32'hFFF10093, 32'h0, 32'd10, 32'h0, mk(32'd10, 32'hFFFFFFFF, 4'b0010, 1'b0, 1'b0));
    issue(32'h40415093, 32'h0, 32'h80000000, 32'h0, mk(32'h80000000, 32'h00000404, 4'b1000, 1'b0, 1'b0));
    issue(32'h0020E063, 32'h0, 32'd1, 32'hFFFFFFFF, mk(32'd1, 32'hFFFFFFFF, 4'b1110, 1'b1, 1'b0));
    issue(32'h0020A063, 32'h0, 32'd1, 32'd2, mk(32'd0, 32'd0, 4'b0010, 1'b0, 1'b1));
    issue(32'h402081B3, 32'h0, 32'd9, 32'd4, mk(32'd9, 32'd4, 4'b0011, 1'b0, 1'b0));
    issue(32'h022081B3, 32'h0, 32'd9, 32'd4, mk(32'd0, 32'd0, 4'b0010, 1'b0, 1'b1));
    issue(32'h123452B7, 32'h0, 32'hDEAD, 32'h0, mk(32'd0, 32'h12345000, 4'b0010, 1'b0, 1'b0));
    issue(32'hFE20AE23, 32'h0, 32'h1000, 32'h55, mk(32'h1000, 32'hFFFFFFFC, 4'b0010, 1'b0, 1'b0));
    issue(32'h0000006F, 32'h200, 32'h0, 32'h0, mk(32'h200, 32'd4, 4'b0010, 1'b0, 1'b0));
    issue(32'h00001067, 32'h200, 32'h0, 32'h0, mk(32'd0, 32'd0, 4'b0010, 1'b0, 1'b1));
    issue(32'h00000000, 32'h0, 32'h0, 32'h0, mk(32'd0, 32'd0, 4'b0010, 1'b0, 1'b1));
    issue(32'h40011093, 32'h0, 32'h3, 32'h0, mk(32'd0, 32'd0, 4'b0010, 1'b0, 1'b1));
    issue(32'h0020D063, 32'h0, 32'hFFFFFFF0, 32'd3, mk(32'hFFFFFFF0, 32'd3, 4'b1100, 1'b1, 1'b0));
    drain();

    // Back-pressure: third back-to-back push must see in_ready low
    out_ready = 1'b0;
    issue(32'h00110093, 32'h0, 32'd1, 32'h0, mk(32'd1, 32'd1, 4'b0010, 1'b0, 1'b0));
    issue(32'h00214093, 32'h0, 32'd2, 32'h0, mk(32'd2, 32'd2, 4'b0100, 1'b0, 1'b0));
    in_valid = 1'b1; instr = 32'h00316093; rs1_data = 32'd3;
    @(negedge clk);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    chk("stall_hold_srca", SrcA, 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Flush with one entry held and an acceptable input in the same cycle
    out_ready = 1'b0;
    issue(32'h002081B3, 32'h0, 32'd11, 32'd12, mk(32'd11, 32'd12, 4'b0010, 1'b0, 1'b0));
    flush = 1'b1;
    issue(32'h402081B3, 32'h0, 32'd13, 32'd14, mk(32'd13, 32'd14, 4'b0011, 1'b0, 1'b0));
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush1_out_valid", 32'(out_valid), 32'd0);
    chk("flush1_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Flush with two entries held
    issue(32'h002081B3, 32'h0, 32'd21, 32'd22, mk(32'd21, 32'd22, 4'b0010, 1'b0, 1'b0));
    issue(32'h002081B3, 32'h0, 32'd23, 32'd24, mk(32'd23, 32'd24, 4'b0010, 1'b0, 1'b0));
    flush = 1'b1;
    issue(32'h002081B3, 32'h0, 32'd25, 32'd26, mk(32'd25, 32'd26, 4'b0010, 1'b0, 1'b0));
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush2_out_valid", 32'(out_valid), 32'd0);
    chk("flush2_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    idle(4);

    // Asynchronous reset while stalled with two entries
    out_ready = 1'b0;
    issue(32'h002081B3, 32'h0, 32'd31, 32'd32, mk(32'd31, 32'd32, 4'b0010, 1'b0, 1'b0));
    issue(32'h0020E063, 32'h0, 32'd33, 32'd34, mk(32'd33, 32'd34, 4'b1110, 1'b1, 1'b0));
    in_valid = 1'b0;
    #1;
    chk("prereset_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    chk("midreset_srca", SrcA, 32'd0);
    chk("midreset_srcb", SrcB, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(32'h00000097, 32'h100, 32'h0, 32'h0, mk(32'h100, 32'd0, 4'b0010, 1'b0, 1'b0));
    drain();
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
